dmawr_chunk_splitter: RTL and testbench
=======================================

Name: dmawr_chunk_splitter

Overview:
- Upstream neighbour of dmawr2tlp. Accepts one host-buffer write command (64-bit address, byte count) per transfer.
- Emits a stream of sub-requests, each sized for a single memory-write TLP.
- Every sub-request is no larger than the negotiated max payload size and never crosses a max-payload-aligned boundary, which also guarantees it never crosses a 4 KB page.
- dmawr2tlp consumes the sub-requests directly through a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 64, host address width.
- BCOUNT_WIDTH, 24, command byte-count width.
- MAX_PAYLOAD_BYTES, 512, hard ceiling on chunk size; power of two, 128..4096.
- TAG_WIDTH, 4, opaque command tag passed to every chunk.

Ports:
- sys_clk  in  1  clock.
- sys_reset  in  1  synchronous, active-high reset.
- cfg_mps  in  3  PCIe max-payload encoding; bytes = 128 << cfg_mps; values 6..7 are treated as 5.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_bcount  in  BCOUNT_WIDTH  total bytes.
- cmd_tag  in  TAG_WIDTH  command tag.
- req_valid  out  1  chunk valid.
- req_ready  in  1  downstream ready.
- req_addr  out  ADDR_WIDTH  chunk start address.
- req_bcount  out  13  chunk bytes, 1..4096.
- req_tag  out  TAG_WIDTH  copy of cmd_tag.
- req_first  out  1  first chunk of the command.
- req_last  out  1  last chunk of the command.
- busy  out  1  high while in SPLIT.
- err_zero_len  out  1  one-cycle pulse when a zero-length command is accepted.

Behaviour:
Reset values:
- cmd_ready=1, req_valid=0, busy=0, err_zero_len=0.
- req_addr, req_bcount, req_tag, req_first and req_last are all 0.

Effective MPS (mps_b):
- mps_b = min(128 << min(cfg_mps, 5), MAX_PAYLOAD_BYTES).
- mps_b is sampled once, at command acceptance; changing cfg_mps mid-command has no effect on that command.

State machine, IDLE / SPLIT:
- IDLE: cmd_ready=1.
  - Accept with cmd_bcount=0: stay in IDLE, pulse err_zero_len for the following cycle, emit no chunk.
  - Accept with cmd_bcount>0: register cur_addr=cmd_addr, remaining=cmd_bcount, tag, first=1; go to SPLIT.
- SPLIT: cmd_ready=0. In each cycle where the output register is empty or being drained (req_valid=0, or req_valid and req_ready both high), load the next chunk:
  - chunk = min(remaining, mps_b - (cur_addr mod mps_b)).
  - req_addr=cur_addr, req_bcount=chunk, req_first=first, req_last=(remaining==chunk).
  - Then update cur_addr += chunk (full ADDR_WIDTH add, wraps modulo 2^ADDR_WIDTH), remaining -= chunk, first=0.
  - After the last chunk is loaded, no further chunks are loaded. Return to IDLE when that last chunk handshakes; cmd_ready rises in the following cycle.

Timing:
- Latency: command accepted in cycle N gives req_valid=1 in cycle N+1.
- Throughput: one chunk per cycle while req_ready=1.
- No overlap between commands: a new command is accepted only after the last chunk of the previous one has handshaked.

Handshake rules:
- While req_valid=1 and req_ready=0, all req_* outputs hold stable.
- req_valid never drops without a handshake, except on reset.

Width rules:
- mod and min use the low 13 bits of the address.
- remaining is BCOUNT_WIDTH wide and never underflows, because chunk ≤ remaining.

Boundary conditions:
- Address already mps-aligned: every chunk except possibly the last equals mps_b.
- remaining < mps_b on the first chunk: a single chunk with first=last=1.

Reset mid-operation:
- Any state goes to IDLE in the next cycle.
- req_valid=0, and the in-flight command is discarded.
- err_zero_len is cleared.

Decomposition:
- Package dmawr2tlp_types_pkg holds:
  - the state enum;
  - the function mps_decode(cfg_mps, max) returning mps_b;
  - the constant PAGE_BYTES=4096;
  - the struct dmawr_chunk_t (addr, bcount, tag, first, last), which dmawr2tlp also uses.
- One sub-module, dmawr_chunk_calc: combinational chunk-size and last computation from cur_addr, remaining and mps_b. It is reused by the scoreboard reference model.

Test Plan:
1. cfg_mps=1 (256 B), addr 0x0000_1000, bcount 1024:
   - Expect 4 chunks of 0x100 at 0x1000, 0x1100, 0x1200, 0x1300.
   - first on chunk 0, last on chunk 3, req_valid first seen one cycle after acceptance.
2. cfg_mps=1, addr 0x0FF0, bcount 0x130:
   - Expect chunks 0x10@0x0FF0, 0x100@0x1000, 0x20@0x1100.
   - No chunk crosses a 256 B or 4 KB boundary.
3. Backpressure during 2: hold req_ready low 3 cycles mid-command.
   - All req_* outputs stable, no chunk lost or duplicated, total bytes 0x130.
4. cmd_bcount=0, tag 5:
   - No req_valid, err_zero_len high exactly one cycle, cmd_ready stays 1.
5. cfg_mps=7 with MAX_PAYLOAD_BYTES=512, addr 0, bcount 2048:
   - Expect 4 chunks of 512.
   - Change cfg_mps to 0 mid-command: chunk size stays 512.
6. Assert sys_reset during chunk 2 of scenario 1:
   - Next cycle req_valid=0, busy=0, cmd_ready=1.
   - A following command addr 0x2000, bcount 0x80 gives a single chunk with first=last=1.

Source files
------------

// File: rtl/dmawr2tlp_types_pkg.sv
// Types shared by the DMA-write splitter and dmawr2tlp: chunk record, splitter states, MPS decode.
// Pure declarations: no latency and no handshake of its own.
package dmawr2tlp_types_pkg;
    localparam int PAGE_BYTES   = 4096;
    localparam int CHUNK_ADDR_W = 64;
    localparam int CHUNK_TAG_W  = 4;
    localparam int CHUNK_BC_W   = 13;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_t;

    typedef struct packed {
        logic [CHUNK_ADDR_W-1:0] addr;
        logic [CHUNK_BC_W-1:0]   bcount;
        logic [CHUNK_TAG_W-1:0]  tag;
        logic                    first;
        logic                    last;
    } dmawr_chunk_t;

    // PCIe MPS encodings above 5 are reserved and behave as 4 KB; the result is then capped.
    function automatic logic [CHUNK_BC_W-1:0] mps_decode(input logic [2:0] cfg_mps,
                                                         input int         max_bytes);
        logic [2:0]            code;
        logic [CHUNK_BC_W-1:0] bytes;
        code  = (cfg_mps > 3'd5) ? 3'd5 : cfg_mps;
        bytes = 13'd128 << code;
        if (32'(bytes) > max_bytes) begin
            bytes = CHUNK_BC_W'(max_bytes);
        end
        return bytes;
    endfunction
endpackage

// File: rtl/dmawr_chunk_calc.sv
// Chunk sizing: bytes up to the next mps_b-aligned boundary, capped by what remains.
// Purely combinational (zero latency), no handshake; the caller decides when to use it.
module dmawr_chunk_calc
#(
    parameter int BCOUNT_WIDTH = 24
) (
    input  logic [12:0]             i_addr_lo,
    input  logic [BCOUNT_WIDTH-1:0] i_remaining,
    input  logic [12:0]             i_mps_b,
    output logic [12:0]             o_chunk,
    output logic                    o_last
);
    logic [12:0] w_offset;
    logic [12:0] w_room;
    logic        w_fits;

    // mps_b is a power of two, so the modulo is a mask; room is 1..mps_b.
    assign w_offset = i_addr_lo & (i_mps_b - 13'd1);
    assign w_room   = i_mps_b - w_offset;
    assign w_fits   = (i_remaining <= BCOUNT_WIDTH'(w_room));
    assign o_chunk  = w_fits ? 13'(i_remaining) : w_room;
    assign o_last   = w_fits;
endmodule

// File: rtl/dmawr_chunk_splitter.sv
// Splits a host write command into MPS-bounded chunks; first chunk valid the cycle after accept.
// Output register holds under req_ready low; one chunk per cycle otherwise; no command overlap.
module dmawr_chunk_splitter
    import dmawr2tlp_types_pkg::*;
#(
    parameter int ADDR_WIDTH        = 64,
    parameter int BCOUNT_WIDTH      = 24,
    parameter int MAX_PAYLOAD_BYTES = 512,
    parameter int TAG_WIDTH         = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset,
    input  logic [2:0]              cfg_mps,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [BCOUNT_WIDTH-1:0] cmd_bcount,
    input  logic [TAG_WIDTH-1:0]    cmd_tag,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [12:0]             req_bcount,
    output logic [TAG_WIDTH-1:0]    req_tag,
    output logic                    req_first,
    output logic                    req_last,
    output logic                    busy,
    output logic                    err_zero_len
);
    localparam int MPS_CEIL = (MAX_PAYLOAD_BYTES > PAGE_BYTES) ? PAGE_BYTES : MAX_PAYLOAD_BYTES;

    split_state_t            r_state;
    dmawr_chunk_t            r_req;
    logic                    r_req_vld;
    logic                    r_cmd_rdy;
    logic                    r_busy;
    logic                    r_err_zero_len;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [BCOUNT_WIDTH-1:0] r_remaining;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [12:0]             r_mps_b;
    logic                    r_first;
    logic                    r_all_loaded;

    logic                    w_in_idle;
    logic                    w_cmd_fire;
    logic                    w_req_fire;
    logic                    w_load;
    logic [ADDR_WIDTH-1:0]   w_base_addr;
    logic [BCOUNT_WIDTH-1:0] w_base_rem;
    logic [12:0]             w_base_mps;
    logic [TAG_WIDTH-1:0]    w_base_tag;
    logic                    w_base_first;
    logic [12:0]             w_chunk;
    logic                    w_last;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_cmd_fire = r_cmd_rdy & cmd_valid;
    assign w_req_fire = r_req_vld & req_ready;

    // In IDLE the first chunk is sized straight from the command so it is valid one cycle later.
    assign w_base_addr  = w_in_idle ? cmd_addr : r_cur_addr;
    assign w_base_rem   = w_in_idle ? cmd_bcount : r_remaining;
    assign w_base_mps   = w_in_idle ? mps_decode(cfg_mps, MPS_CEIL) : r_mps_b;
    assign w_base_tag   = w_in_idle ? cmd_tag : r_tag;
    assign w_base_first = w_in_idle ? 1'b1 : r_first;

    assign w_load = w_in_idle ? (w_cmd_fire && (cmd_bcount != '0))
                              : (!r_all_loaded && (!r_req_vld || req_ready));

    dmawr_chunk_calc #(
        .BCOUNT_WIDTH (BCOUNT_WIDTH)
    ) u_calc (
        .i_addr_lo   (w_base_addr[12:0]),
        .i_remaining (w_base_rem),
        .i_mps_b     (w_base_mps),
        .o_chunk     (w_chunk),
        .o_last      (w_last)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state        <= ST_IDLE;
            r_req          <= '0;
            r_req_vld      <= 1'b0;
            r_cmd_rdy      <= 1'b1;
            r_busy         <= 1'b0;
            r_err_zero_len <= 1'b0;
            r_cur_addr     <= '0;
            r_remaining    <= '0;
            r_tag          <= '0;
            r_mps_b        <= '0;
            r_first        <= 1'b0;
            r_all_loaded   <= 1'b0;
        end else begin
            r_err_zero_len <= w_cmd_fire && (cmd_bcount == '0);

            if (w_load) begin
                r_req.addr   <= CHUNK_ADDR_W'(w_base_addr);
                r_req.bcount <= w_chunk;
                r_req.tag    <= CHUNK_TAG_W'(w_base_tag);
                r_req.first  <= w_base_first;
                r_req.last   <= w_last;
                r_req_vld    <= 1'b1;
                r_cur_addr   <= w_base_addr + ADDR_WIDTH'(w_chunk);
                r_remaining  <= w_base_rem - BCOUNT_WIDTH'(w_chunk);
                r_first      <= 1'b0;
                r_all_loaded <= w_last;
            end else if (w_req_fire) begin
                r_req_vld    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state   <= ST_SPLIT;
                        r_cmd_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_mps_b   <= w_base_mps;
                        r_tag     <= cmd_tag;
                    end
                end
                ST_SPLIT: begin
                    if (w_req_fire && r_req.last) begin
                        r_state   <= ST_IDLE;
                        r_cmd_rdy <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = r_cmd_rdy;
    assign req_valid    = r_req_vld;
    assign req_addr     = r_req.addr[ADDR_WIDTH-1:0];
    assign req_bcount   = r_req.bcount;
    assign req_tag      = r_req.tag[TAG_WIDTH-1:0];
    assign req_first    = r_req.first;
    assign req_last     = r_req.last;
    assign busy         = r_busy;
    assign err_zero_len = r_err_zero_len;
endmodule

// File: tb/tb_dmawr_chunk_splitter.sv
// Bench for dmawr_chunk_splitter: directed scenarios plus randomized commands vs. an arithmetic model.
module tb_dmawr_chunk_splitter;
    localparam int AW  = 64;
    localparam int BW  = 24;
    localparam int MPB = 512;
    localparam int TW  = 4;

    logic          sys_clk = 1'b0;
    logic          sys_reset;
    logic [2:0]    cfg_mps;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_bcount;
    logic [TW-1:0] cmd_tag;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [12:0]   req_bcount;
    logic [TW-1:0] req_tag;
    logic          req_first;
    logic          req_last;
    logic          busy;
    logic          err_zero_len;

    always #5 sys_clk = ~sys_clk;

    dmawr_chunk_splitter #(
        .ADDR_WIDTH        (AW),
        .BCOUNT_WIDTH      (BW),
        .MAX_PAYLOAD_BYTES (MPB),
        .TAG_WIDTH         (TW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .cfg_mps      (cfg_mps),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_bcount   (cmd_bcount),
        .cmd_tag      (cmd_tag),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_bcount   (req_bcount),
        .req_tag      (req_tag),
        .req_first    (req_first),
        .req_last     (req_last),
        .busy         (busy),
        .err_zero_len (err_zero_len)
    );

    typedef struct {
        logic [63:0] addr;
        int unsigned bc;
        logic [3:0]  tag;
        logic        first;
        logic        last;
    } chk_t;

    chk_t obs_q[$];
    chk_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   timed_out, hold_bad;
    logic vld_n1, busy_n1, ready_after, busy_after, extra_vld;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int unsigned model_mps(input int cfg);
        int unsigned m;
        m = 128 << ((cfg > 5) ? 5 : cfg);
        if (m > MPB) m = MPB;
        return m;
    endfunction

    // Reference: walk the byte range, cutting at every multiple of mps.
    function automatic void build_exp(input logic [63:0] a, input int unsigned bc,
                                      input logic [3:0] t, input int cfg);
        int unsigned mps, rem, room, c;
        logic [63:0] cur;
        bit          first;
        mps = model_mps(cfg);
        rem = bc;
        cur = a;
        first = 1'b1;
        exp_q.delete();
        while (rem > 0) begin
            room = mps - 32'(cur % 64'(mps));
            c = (rem < room) ? rem : room;
            exp_q.push_back('{cur, c, t, first, (rem == c)});
            cur = cur + 64'(c);
            rem = rem - c;
            first = 1'b0;
        end
    endfunction

    // Monitor/driver only: issues one command and records every handshaken chunk.
    task automatic run_cmd(input logic [63:0] a, input int unsigned bc, input logic [3:0] t,
                           input int stall_at, input int stall_len, input bit rand_rdy,
                           input int chg_at, input logic [2:0] chg_val);
        int   c;
        bit   done, held;
        chk_t snap, cur;
        obs_q.delete();
        timed_out = 0; hold_bad = 0; done = 0; held = 0; c = 0;
        while (!cmd_ready && c < 100) begin tick(); c++; end
        if (!cmd_ready) timed_out = 1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_bcount = BW'(bc); cmd_tag = t; req_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        vld_n1 = req_valid;
        busy_n1 = busy;
        c = 0;
        while (!done && c < 400) begin
            if (c == chg_at) cfg_mps = chg_val;
            req_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : !(c >= stall_at && c < stall_at + stall_len);
            cur.addr = req_addr; cur.bc = 32'(req_bcount); cur.tag = req_tag;
            cur.first = req_first; cur.last = req_last;
            if (held && (!req_valid || cur.addr !== snap.addr || cur.bc !== snap.bc ||
                         cur.tag !== snap.tag || cur.first !== snap.first || cur.last !== snap.last))
                hold_bad = 1;
            held = req_valid && !req_ready;
            if (held) snap = cur;
            if (req_valid && req_ready) begin
                obs_q.push_back(cur);
                if (req_last) done = 1;
            end
            tick();
            c++;
        end
        if (!done) timed_out = 1;
        req_ready = 1'b0;
        ready_after = cmd_ready;
        busy_after = busy;
        extra_vld = req_valid;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1; cmd_valid = 1'b0; req_ready = 1'b0; cfg_mps = 3'd1;
        cmd_addr = '0; cmd_bcount = '0; cmd_tag = '0;
        tick(); tick();
        n_cmp++;
        if ({cmd_ready, req_valid, busy, err_zero_len} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy/vld/busy/err=%b want 1000", {cmd_ready, req_valid, busy, err_zero_len});
        end
        n_cmp++;
        if ({req_addr, req_bcount, req_tag, req_first, req_last} !== '0) begin
            n_bad++;
            $display("FAIL reset_req: got addr=%h bc=%h tag=%h f=%b l=%b want all 0", req_addr, req_bcount, req_tag, req_first, req_last);
        end
        sys_reset = 1'b0;
        tick();
    endtask

    task automatic test_aligned();
        cfg_mps = 3'd1;
        build_exp(64'h1000, 1024, 4'h3, 1);
        run_cmd(64'h1000, 1024, 4'h3, -1, 0, 1'b0, -1, 3'd1);
        n_cmp++;
        if (timed_out || vld_n1 !== 1'b1 || busy_n1 !== 1'b1) begin
            n_bad++;
            $display("FAIL aligned_latency: got timeout=%0d vld=%b busy=%b want 0 1 1", timed_out, vld_n1, busy_n1);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL aligned_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].bc !== exp_q[i].bc || obs_q[i].tag !== exp_q[i].tag ||
                obs_q[i].first !== exp_q[i].first || obs_q[i].last !== exp_q[i].last) begin
                n_bad++;
                $display("FAIL aligned_chunk%0d: got %h/%h/%h/%b%b want %h/%h/%h/%b%b", i,
                         obs_q[i].addr, obs_q[i].bc, obs_q[i].tag, obs_q[i].first, obs_q[i].last,
                         exp_q[i].addr, exp_q[i].bc, exp_q[i].tag, exp_q[i].first, exp_q[i].last);
            end
        end
        n_cmp++;
        if (ready_after !== 1'b1 || busy_after !== 1'b0 || extra_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL aligned_done: got rdy=%b busy=%b vld=%b want 1 0 0", ready_after, busy_after, extra_vld);
        end
    endtask

    task automatic test_unaligned_backpressure();
        int unsigned total;
        cfg_mps = 3'd1;
        build_exp(64'h0FF0, 32'h130, 4'h9, 1);
        run_cmd(64'h0FF0, 32'h130, 4'h9, 1, 3, 1'b0, -1, 3'd1);
        n_cmp++;
        if (timed_out || hold_bad) begin
            n_bad++;
            $display("FAIL bp_hold: got timeout=%0d unstable=%0d want 0 0", timed_out, hold_bad);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        total = 0;
        foreach (obs_q[i]) begin
            total += obs_q[i].bc;
            n_cmp++;
            if ((obs_q[i].addr % 256) + obs_q[i].bc > 256 || (obs_q[i].addr % 4096) + obs_q[i].bc > 4096) begin
                n_bad++;
                $display("FAIL bp_boundary%0d: got addr=%h bc=%h want no 256B/4KB crossing", i, obs_q[i].addr, obs_q[i].bc);
            end
            if (i < exp_q.size()) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].bc !== exp_q[i].bc ||
                    obs_q[i].first !== exp_q[i].first || obs_q[i].last !== exp_q[i].last) begin
                    n_bad++;
                    $display("FAIL bp_chunk%0d: got %h/%h/%b%b want %h/%h/%b%b", i,
                             obs_q[i].addr, obs_q[i].bc, obs_q[i].first, obs_q[i].last,
                             exp_q[i].addr, exp_q[i].bc, exp_q[i].first, exp_q[i].last);
                end
            end
        end
        n_cmp++;
        if (total != 32'h130) begin
            n_bad++;
            $display("FAIL bp_total: got %h want 130", total);
        end
    endtask

    task automatic test_zero_len();
        bit bad;
        cmd_valid = 1'b1; cmd_addr = 64'h4000; cmd_bcount = '0; cmd_tag = 4'd5;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (err_zero_len !== 1'b1 || cmd_ready !== 1'b1 || req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_pulse: got err=%b rdy=%b vld=%b want 1 1 0", err_zero_len, cmd_ready, req_valid);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (err_zero_len !== 1'b0 || cmd_ready !== 1'b1 || req_valid !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL zero_after: got err/rdy/vld off-nominal want 0 1 0 for 5 cycles");
        end
    endtask

    task automatic test_mps_clamp();
        cfg_mps = 3'd7;
        build_exp(64'h0, 2048, 4'hA, 7);
        run_cmd(64'h0, 2048, 4'hA, -1, 0, 1'b0, 1, 3'd0);
        n_cmp++;
        if (timed_out || obs_q.size() != 4) begin
            n_bad++;
            $display("FAIL clamp_count: got %0d timeout=%0d want 4 0", obs_q.size(), timed_out);
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].bc !== exp_q[i].bc || obs_q[i].last !== exp_q[i].last) begin
                n_bad++;
                $display("FAIL clamp_chunk%0d: got %h/%h/%b want %h/%h/%b", i,
                         obs_q[i].addr, obs_q[i].bc, obs_q[i].last, exp_q[i].addr, exp_q[i].bc, exp_q[i].last);
            end
        end
        cfg_mps = 3'd1;
    endtask

    task automatic test_reset_mid();
        cfg_mps = 3'd1;
        cmd_valid = 1'b1; cmd_addr = 64'h1000; cmd_bcount = 24'd1024; cmd_tag = 4'h1;
        tick();
        cmd_valid = 1'b0; req_ready = 1'b1;
        tick(); tick();
        req_ready = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b1 || req_addr !== 64'h1200) begin
            n_bad++;
            $display("FAIL rstmid_chunk2: got vld=%b addr=%h want 1 1200", req_valid, req_addr);
        end
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_state: got vld=%b busy=%b rdy=%b want 0 0 1", req_valid, busy, cmd_ready);
        end
        run_cmd(64'h2000, 32'h80, 4'h2, -1, 0, 1'b0, -1, 3'd1);
        n_cmp++;
        if (timed_out || obs_q.size() != 1 || obs_q[0].addr !== 64'h2000 || obs_q[0].bc !== 32'h80 ||
            obs_q[0].first !== 1'b1 || obs_q[0].last !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_next: got n=%0d addr=%h bc=%h f=%b l=%b want 1 2000 80 1 1", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0].addr : 64'h0, (obs_q.size() > 0) ? obs_q[0].bc : 0,
                     (obs_q.size() > 0) ? obs_q[0].first : 1'b0, (obs_q.size() > 0) ? obs_q[0].last : 1'b0);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        int unsigned bc, mps;
        int          cfg;
        logic [3:0]  t;
        for (int it = 0; it < 40; it++) begin
            cfg = $urandom_range(0, 7);
            cfg_mps = 3'(cfg);
            a = {$urandom, $urandom};
            if (it == 0) a = 64'hFFFF_FFFF_FFFF_FF40;
            else if (it % 4 == 1) a[12:0] = 13'h1000 - 13'($urandom_range(1, 64));
            bc = $urandom_range(1, 3000);
            t = 4'($urandom_range(0, 15));
            mps = model_mps(cfg);
            build_exp(a, bc, t, cfg);
            run_cmd(a, bc, t, -1, 0, 1'b1, -1, 3'(cfg));
            n_cmp++;
            if (timed_out || hold_bad || obs_q.size() != exp_q.size() || ready_after !== 1'b1) begin
                n_bad++;
                $display("FAIL rand%0d_flow: got n=%0d timeout=%0d unstable=%0d rdy=%b want n=%0d 0 0 1", it,
                         obs_q.size(), timed_out, hold_bad, ready_after, exp_q.size());
            end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                n_cmp++;
                if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].bc !== exp_q[i].bc || obs_q[i].tag !== exp_q[i].tag ||
                    obs_q[i].first !== exp_q[i].first || obs_q[i].last !== exp_q[i].last ||
                    (obs_q[i].addr % 64'(mps)) + 64'(obs_q[i].bc) > 64'(mps)) begin
                    n_bad++;
                    $display("FAIL rand%0d_chunk%0d: got %h/%h/%h/%b%b want %h/%h/%h/%b%b mps=%0d", it, i,
                             obs_q[i].addr, obs_q[i].bc, obs_q[i].tag, obs_q[i].first, obs_q[i].last,
                             exp_q[i].addr, exp_q[i].bc, exp_q[i].tag, exp_q[i].first, exp_q[i].last, mps);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_aligned();
        test_unaligned_backpressure();
        test_zero_len();
        test_mps_clamp();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
